qos_egress_mux: RTL and testbench
=================================

// Module: qos_egress_mux
// PURPOSE
// Egress stage after the weighted QoS arbiter in the PCIe QoS path. Samples the
// arbiter's one-hot pop vector, captures the word the popped VC FIFO presents one
// cycle later, and emits it as a registered stream tagged with its source class.
// Keeps per-class egress word counters, readable through a request/response port.
// PARAMETERS
// DATA_W       12  width of each FIFO data word and of data_out
// CNT_W        8   width of each per-class egress counter (wraps)
// IDLE_CYCLES  4   consecutive pop-free cycles before ACTIVE returns to IDLE (>=1)
// PORTS
// clk        in   1          clock, all state updates on rising edge
// reset      in   1          synchronous, active-low
// pop        in   4          arbiter pop vector; bit k = pop of VC FIFO k (k=0 weight 4)
// data_in0   in   DATA_W     read data of VC FIFO 0, valid the cycle after its pop
// data_in1   in   DATA_W     read data of VC FIFO 1, same timing
// data_in2   in   DATA_W     read data of VC FIFO 2, same timing
// data_in3   in   DATA_W     read data of VC FIFO 3, same timing
// req        in   1          counter read request, one-cycle pulse
// req_idx    in   2          class whose counter is read when req=1
// clr_cnt    in   1          clear all counters, one-cycle pulse
// data_out   out  DATA_W     egress word
// valid_out  out  1          data_out/class_out valid this cycle
// class_out  out  2          source FIFO index of data_out
// cnt_out    out  CNT_W      counter value for the last req
// cnt_valid  out  1          one-cycle pulse, cnt_out valid
// idle       out  1          1 while FSM is in IDLE
// err        out  1          sticky: pop with more than one bit set was seen
// BEHAVIOUR
// - Reset (reset=0 at edge): data_out=0, valid_out=0, class_out=0, cnt_out=0,
//   cnt_valid=0, idle=1, err=0, all counters=0, pop pipeline cleared, FSM=IDLE.
//   Reset mid-stream discards any word in flight; no valid_out for it afterwards.
// - Pipeline: edge E0 registers pop (pop_q) and sel=index of its lowest set bit.
//   Edge E1 registers data_in[sel] into data_out, sel into class_out, valid_out=1.
//   Latency: pop high in cycle t -> valid_out high in cycle t+2. Full throughput:
//   one pop per cycle gives one valid_out per cycle, in pop order.
// - pop_q==0 at E1 -> valid_out=0; data_out and class_out hold previous values.
// - pop with >1 bit set: lowest index wins, others ignored; err set at E0, stays 1
//   until reset.
// - Counters: cnt[class] increments by 1 on each edge that sets valid_out=1;
//   wraps 2^CNT_W-1 -> 0. clr_cnt=1 clears all counters at that edge; clear wins over
//   a simultaneous increment (that word is not counted).
// - Read: req=1 at edge -> cnt_out=cnt[req_idx] value before that edge's update,
//   cnt_valid=1 for exactly the following cycle. req=0 -> cnt_valid=0, cnt_out holds.
//   req and clr_cnt same edge: cnt_out returns pre-clear value.
// - FSM (idle flag only, datapath unaffected):
//   IDLE: pop!=0 -> ACTIVE (idle=0 next cycle), else stay.
//   ACTIVE: idle counter resets to 0 on any pop!=0, else increments; reaching
//   IDLE_CYCLES -> IDLE. Counter is ceil(log2(IDLE_CYCLES+1)) bits, never wraps.
// TESTING
// - Reset: reset=0 2 cycles with pop=4'hF -> all outputs at reset values, err=0.
// - Single pop: pop=4'b0010 cycle t, data_in1=12'h1A5 cycle t+1 -> cycle t+2
//   valid_out=1, data_out=12'h1A5, class_out=1; req idx 1 later -> cnt_out=1.
// - Burst: pops 0,0,0,0,1,1,1,2,2,3 back-to-back -> 10 consecutive valid_out,
//   classes 0,0,0,0,1,1,1,2,2,3; counters read back 4,3,2,1; idle=1 4 cycles
//   after the last pop.
// - Illegal pop: pop=4'b0110 with data_in1=12'h011 -> data_out=12'h011,
//   class_out=1, err=1 and remains 1 after 20 clean cycles.
// - Wrap and clear: 256 pops of FIFO 3 (CNT_W=8) -> cnt[3] reads 0; clr_cnt on the
//   edge of a valid FIFO 2 word -> cnt[2] reads 0; req+clr same edge -> pre-clear value.
// - Reset mid-stream: pop=4'b0001 cycle t, reset=0 at t+1 -> no valid_out at t+2,
//   counters 0, idle=1.

Source files
------------

// File: rtl/qos_egress_mux.sv
// Egress stage behind the weighted QoS arbiter: registers the pop vector, captures the
// popped VC FIFO word one cycle later, and keeps per-class egress word counters.
module qos_egress_mux #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        pop,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              req,
  input  logic [1:0]        req_idx,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        class_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              cnt_valid,
  output logic              idle,
  output logic              err
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idle_cnt, idle_cnt_nxt, idle_cnt_inc;
  logic              pop_v_q;
  logic [1:0]        sel_q, sel_d;
  logic              multi_pop;
  logic [DATA_W-1:0] data_sel;
  logic [CNT_W-1:0]  cnt [4];

  // Lowest set bit wins when the arbiter raises more than one pop.
  always_comb begin
    sel_d = 2'd0;
    if (pop[0])      sel_d = 2'd0;
    else if (pop[1]) sel_d = 2'd1;
    else if (pop[2]) sel_d = 2'd2;
    else if (pop[3]) sel_d = 2'd3;
  end

  assign multi_pop = (pop & (pop - 4'd1)) != 4'd0;

  always_comb begin
    case (sel_q)
      2'd0:    data_sel = data_in0;
      2'd1:    data_sel = data_in1;
      2'd2:    data_sel = data_in2;
      default: data_sel = data_in3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_v_q   <= 1'b0;
      sel_q     <= 2'd0;
      data_out  <= '0;
      valid_out <= 1'b0;
      class_out <= 2'd0;
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      err       <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      pop_v_q   <= |pop;
      sel_q     <= sel_d;
      valid_out <= pop_v_q;
      if (pop_v_q) begin
        data_out  <= data_sel;
        class_out <= sel_q;
      end
      if (multi_pop) err <= 1'b1;
      cnt_valid <= req;
      if (req) cnt_out <= cnt[req_idx];
      // Clear takes priority over the increment of a word leaving on the same edge.
      for (int unsigned k = 0; k < 4; k++) begin
        if (clr_cnt)
          cnt[k] <= '0;
        else if (pop_v_q && sel_q == 2'(k))
          cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  assign idle_cnt_inc = idle_cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    case (state)
      S_IDLE: begin
        idle_cnt_nxt = '0;
        if (|pop) state_nxt = S_ACTIVE;
      end
      default: begin
        if (|pop) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt_inc == IW'(IDLE_CYCLES)) begin
          idle_cnt_nxt = '0;
          state_nxt    = S_IDLE;
        end else begin
          idle_cnt_nxt = idle_cnt_inc;
        end
      end
    endcase
  end

  assign idle = (state == S_IDLE);

endmodule

// File: tb/tb_qos_egress_mux.sv
// Directed bench for qos_egress_mux: expected words queued as FIFO data is presented,
// popped and compared when valid_out appears; counters, err and idle tracked alongside.
module tb_qos_egress_mux;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned IDLE_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        pop;
  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic              req;
  logic [1:0]        req_idx;
  logic              clr_cnt;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [1:0]        class_out;
  logic [CNT_W-1:0]  cnt_out;
  logic              cnt_valid;
  logic              idle;
  logic              err;

  always #5 clk = ~clk;

  qos_egress_mux #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pop      (pop),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .req      (req),
    .req_idx  (req_idx),
    .clr_cnt  (clr_cnt),
    .data_out (data_out),
    .valid_out(valid_out),
    .class_out(class_out),
    .cnt_out  (cnt_out),
    .cnt_valid(cnt_valid),
    .idle     (idle),
    .err      (err)
  );

  typedef struct packed {
    logic [1:0]        cls;
    logic [DATA_W-1:0] d;
  } word_t;

  word_t             sb[$];
  int                checks = 0;
  int                errors = 0;

  logic              pend_v   = 1'b0;
  logic [1:0]        pend_sel = 2'd0;
  logic [CNT_W-1:0]  mcnt [4];
  logic [DATA_W-1:0] exp_data;
  logic [1:0]        exp_class;
  logic [CNT_W-1:0]  exp_cnt;
  logic              exp_cv;
  logic              exp_err;
  logic              exp_idle;
  int                quiet;
  logic              force_v = 1'b0;
  logic [DATA_W-1:0] force_w = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] p);
    logic [1:0] s;
    logic       found;
    s = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && !found) begin
        s = 2'(i);
        found = 1'b1;
      end
    end
    return s;
  endfunction

  // One clock cycle: drive inputs, advance the model, then check at the next negedge.
  task automatic cyc(input logic rs, input logic [3:0] p, input logic r,
                     input logic [1:0] ri, input logic c);
    logic [DATA_W-1:0] w;
    logic              have;
    word_t             e;
    reset    = rs;
    pop      = p;
    req      = r;
    req_idx  = ri;
    clr_cnt  = c;
    data_in0 = DATA_W'($urandom);
    data_in1 = DATA_W'($urandom);
    data_in2 = DATA_W'($urandom);
    data_in3 = DATA_W'($urandom);
    have = 1'b0;
    w = '0;
    if (rs && pend_v) begin
      w = force_v ? force_w : DATA_W'($urandom);
      have = 1'b1;
      case (pend_sel)
        2'd0:    data_in0 = w;
        2'd1:    data_in1 = w;
        2'd2:    data_in2 = w;
        default: data_in3 = w;
      endcase
    end
    force_v = 1'b0;
    if (!rs) begin
      sb.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = '0;
      exp_data  = '0;
      exp_class = 2'd0;
      exp_cnt   = '0;
      exp_cv    = 1'b0;
      exp_err   = 1'b0;
      exp_idle  = 1'b1;
      quiet     = 0;
      pend_v    = 1'b0;
      pend_sel  = 2'd0;
    end else begin
      if (have) sb.push_back('{cls: pend_sel, d: w});
      exp_cv = r;
      if (r) exp_cnt = mcnt[ri];
      if (c) begin
        for (int k = 0; k < 4; k++) mcnt[k] = '0;
      end else if (have) begin
        mcnt[pend_sel] = mcnt[pend_sel] + 1'b1;
      end
      if ($countones(p) > 1) exp_err = 1'b1;
      if (|p) begin
        exp_idle = 1'b0;
        quiet    = 0;
      end else if (!exp_idle) begin
        quiet++;
        if (quiet == int'(IDLE_CYCLES)) exp_idle = 1'b1;
      end
      pend_v   = |p;
      pend_sel = lowest(p);
    end
    @(negedge clk);
    chk("valid_out", 32'(valid_out), 32'(have));
    if (valid_out === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      exp_data  = e.d;
      exp_class = e.cls;
    end
    chk("data_out", 32'(data_out), 32'(exp_data));
    chk("class_out", 32'(class_out), 32'(exp_class));
    chk("cnt_valid", 32'(cnt_valid), 32'(exp_cv));
    chk("cnt_out", 32'(cnt_out), 32'(exp_cnt));
    chk("err", 32'(err), 32'(exp_err));
    chk("idle", 32'(idle), 32'(exp_idle));
  endtask

  task automatic nop();
    cyc(1'b1, 4'h0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] idx);
    cyc(1'b1, 4'h0, 1'b1, idx, 1'b0);
  endtask

  initial begin
    // reset with all pops asserted
    cyc(1'b0, 4'hF, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 4'hF, 1'b0, 2'd0, 1'b0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    nop();

    // single pop of FIFO 1
    cyc(1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
    force_v = 1'b1;
    force_w = 12'h1A5;
    nop();
    chk("single_data", 32'(data_out), 32'h1A5);
    chk("single_class", 32'(class_out), 32'h1);
    nop();
    rd(2'd1);
    chk("single_cnt", 32'(cnt_out), 32'h1);

    // clear, then back-to-back burst
    cyc(1'b1, 4'h0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nop();
      chk("burst_not_idle", 32'(idle), 32'h0);
    end
    nop();
    chk("burst_idle", 32'(idle), 32'h1);
    rd(2'd0);
    chk("burst_cnt0", 32'(cnt_out), 32'd4);
    rd(2'd1);
    chk("burst_cnt1", 32'(cnt_out), 32'd3);
    rd(2'd2);
    chk("burst_cnt2", 32'(cnt_out), 32'd2);
    rd(2'd3);
    chk("burst_cnt3", 32'(cnt_out), 32'd1);

    // illegal multi-bit pop
    cyc(1'b1, 4'b0110, 1'b0, 2'd0, 1'b0);
    force_v = 1'b1;
    force_w = 12'h011;
    nop();
    chk("illegal_data", 32'(data_out), 32'h011);
    chk("illegal_class", 32'(class_out), 32'h1);
    for (int i = 0; i < 20; i++) nop();
    chk("illegal_err_sticky", 32'(err), 32'h1);

    // counter wrap on FIFO 3
    cyc(1'b1, 4'h0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 256; i++) cyc(1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
    nop();
    nop();
    rd(2'd3);
    chk("wrap_cnt3", 32'(cnt_out), 32'h0);

    // clear on the edge of a valid FIFO 2 word
    cyc(1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 4'h0, 1'b0, 2'd0, 1'b1);
    rd(2'd2);
    chk("clr_cnt2", 32'(cnt_out), 32'h0);

    // read and clear on the same edge return the pre-clear value
    cyc(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    nop();
    cyc(1'b1, 4'h0, 1'b1, 2'd0, 1'b1);
    chk("rdclr_pre", 32'(cnt_out), 32'd2);
    rd(2'd0);
    chk("rdclr_post", 32'(cnt_out), 32'd0);

    // reset while a word is in flight
    cyc(1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
    nop();
    chk("midrst_no_valid", 32'(valid_out), 32'h0);
    chk("midrst_idle", 32'(idle), 32'h1);
    rd(2'd0);
    chk("midrst_cnt0", 32'(cnt_out), 32'h0);
    rd(2'd2);
    chk("midrst_cnt2", 32'(cnt_out), 32'h0);
    for (int i = 0; i < 3; i++) nop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
